// File: rtl/control_pkg.sv
// Shared constants for the parametrised phase sequencer: one-hot bit map,
// fault codes and the internal phase encoding.
package control_pkg;

    // Fixed state-vector bit positions
    localparam int IDX_IDLE   = 0;
    localparam int IDX_FETCH  = 1;
    localparam int IDX_DECODE = 2;
    localparam int IDX_EXEC0  = 3;

    // Tail bits sit after the execute block: index = NUM_FUNC + offset
    localparam int OFS_PC_INC = 3;
    localparam int OFS_HALTED = 4;
    localparam int OFS_FAULT  = 5;

    // Fault codes reported on fault_code
    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_FETCH_TO = 2'd1;
    localparam logic [1:0] FLT_EXEC_TO  = 2'd2;
    localparam logic [1:0] FLT_ILL_FUNC = 2'd3;

    // Compact phase encoding; the execute channel index is held separately
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_FETCH,
        PH_DECODE,
        PH_EXEC,
        PH_PC_INC,
        PH_HALTED,
        PH_FAULT
    } phase_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_rdy and flags the cycle in which the
// count would reach MEM_TIMEOUT without a completion strobe.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic cnt_en,
    input  logic mem_rdy,
    output logic timeout
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear on phase change, otherwise advance on each missed strobe
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_en && !mem_rdy) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A strobe in the limit cycle still counts as completion
    assign timeout = cnt_en && !mem_rdy && (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/control_fsm_p.sv
// Moore phase sequencer: fetch / decode / per-function execute / pc increment,
// with memory wait timeout, illegal-function trap, halt/resume and a
// retired-instruction counter. Outputs depend on registered state only.
module control_fsm_p
    import control_pkg::*;
#(
    parameter int NUM_FUNC    = 4,
    parameter int FUNC_W      = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  resume,
    input  logic [FUNC_W-1:0]     func,
    input  logic                  halt,
    input  logic                  mem_req,
    input  logic                  mem_rdy,
    output logic [NUM_FUNC+5:0]   state,
    output logic                  busy,
    output logic                  fault,
    output logic [1:0]            fault_code,
    output logic [RET_W-1:0]      retired
);
    phase_e              phase_q, phase_d;
    logic [FUNC_W-1:0]   exec_q, exec_d;
    logic                memw_q, memw_d;     // latched mem_req for this EXEC phase
    logic                first_q, first_d;   // first cycle after DECODE
    logic [1:0]          code_q, code_d;
    logic [RET_W-1:0]    ret_q, ret_d;
    logic                wait_en;
    logic                timeout;
    logic                state_chg;

    // Cycles that are waiting on memory: all of FETCH, and EXEC when a request
    // was seen in its first cycle
    assign wait_en = (phase_q == PH_FETCH) ||
                     ((phase_q == PH_EXEC) && (first_q ? mem_req : memw_q));

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_chg),
        .cnt_en  (wait_en),
        .mem_rdy (mem_rdy),
        .timeout (timeout)
    );

    // Next-state logic
    always_comb begin
        phase_d = phase_q;
        exec_d  = exec_q;
        memw_d  = memw_q;
        first_d = (phase_q == PH_DECODE);
        code_d  = code_q;
        ret_d   = ret_q;
        case (phase_q)
            PH_IDLE: begin
                if (en) phase_d = PH_FETCH;
            end
            PH_FETCH: begin
                if (mem_rdy) begin
                    phase_d = PH_DECODE;
                end else if (timeout) begin
                    phase_d = PH_FAULT;
                    code_d  = FLT_FETCH_TO;
                end
            end
            PH_DECODE: begin
                if (halt) begin
                    phase_d = PH_HALTED;
                end else if (int'(func) >= NUM_FUNC) begin
                    phase_d = PH_FAULT;
                    code_d  = FLT_ILL_FUNC;
                end else begin
                    phase_d = PH_EXEC;
                    exec_d  = func;
                end
            end
            PH_EXEC: begin
                if (first_q) memw_d = mem_req;
                if (!wait_en || mem_rdy) begin
                    phase_d = PH_PC_INC;
                end else if (timeout) begin
                    phase_d = PH_FAULT;
                    code_d  = FLT_EXEC_TO;
                end
            end
            PH_PC_INC: begin
                ret_d   = ret_q + 1'b1;
                phase_d = en ? PH_FETCH : PH_IDLE;
            end
            PH_HALTED: begin
                if (resume) phase_d = PH_IDLE;
            end
            PH_FAULT: begin
                phase_d = PH_FAULT;
            end
            default: begin
                phase_d = PH_IDLE;
            end
        endcase
        // Each phase is left at most once per cycle, so a phase change is a state change
        state_chg = (phase_d != phase_q);
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= PH_IDLE;
            exec_q  <= '0;
            memw_q  <= 1'b0;
            first_q <= 1'b0;
            code_q  <= FLT_NONE;
            ret_q   <= '0;
        end else begin
            phase_q <= phase_d;
            exec_q  <= exec_d;
            memw_q  <= memw_d;
            first_q <= first_d;
            code_q  <= code_d;
            ret_q   <= ret_d;
        end
    end

    // One-hot phase vector decoded from the registered phase
    always_comb begin
        state = '0;
        case (phase_q)
            PH_IDLE:   state[IDX_IDLE]   = 1'b1;
            PH_FETCH:  state[IDX_FETCH]  = 1'b1;
            PH_DECODE: state[IDX_DECODE] = 1'b1;
            PH_EXEC: begin
                for (int k = 0; k < NUM_FUNC; k++) begin
                    if (exec_q == FUNC_W'(k)) state[IDX_EXEC0 + k] = 1'b1;
                end
            end
            PH_PC_INC: state[NUM_FUNC + OFS_PC_INC] = 1'b1;
            PH_HALTED: state[NUM_FUNC + OFS_HALTED] = 1'b1;
            PH_FAULT:  state[NUM_FUNC + OFS_FAULT]  = 1'b1;
            default:   state[IDX_IDLE]   = 1'b1;
        endcase
    end

    assign busy       = (phase_q == PH_FETCH) || (phase_q == PH_DECODE) ||
                        (phase_q == PH_EXEC)  || (phase_q == PH_PC_INC);
    assign fault      = (phase_q == PH_FAULT);
    assign fault_code = code_q;
    assign retired    = ret_q;

endmodule

// File: tb/tb_control_fsm_p.sv
// Directed bench for control_fsm_p built with NUM_FUNC=3, RET_W=4 so that the
// illegal-func trap and retired wrap are reachable. State bit map for this
// build: IDLE 0, FETCH 1, DECODE 2, EXEC0..2 3..5, PC_INC 6, HALTED 7, FAULT 8.
// The driver pushes the expected post-edge response; a monitor pops and compares.
module tb_control_fsm_p;

    localparam logic [8:0] S_IDLE  = 9'h001;
    localparam logic [8:0] S_FETCH = 9'h002;
    localparam logic [8:0] S_DEC   = 9'h004;
    localparam logic [8:0] S_E0    = 9'h008;
    localparam logic [8:0] S_E1    = 9'h010;
    localparam logic [8:0] S_E2    = 9'h020;
    localparam logic [8:0] S_PCI   = 9'h040;
    localparam logic [8:0] S_HALT  = 9'h080;
    localparam logic [8:0] S_FLT   = 9'h100;

    typedef struct packed {
        logic [8:0]  st;
        logic [1:0]  code;
        logic [3:0]  ret;
        logic [15:0] tag;
    } exp_t;

    logic       clk, rst, en, resume, halt, mem_req, mem_rdy;
    logic [1:0] func;
    logic [8:0] state;
    logic       busy, fault;
    logic [1:0] fault_code;
    logic [3:0] retired;

    exp_t       q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_ret = 4'd0;
    logic [8:0] last_st = S_IDLE;

    control_fsm_p #(
        .NUM_FUNC    (3),
        .FUNC_W      (2),
        .MEM_TIMEOUT (15),
        .RET_W       (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .resume     (resume),
        .func       (func),
        .halt       (halt),
        .mem_req    (mem_req),
        .mem_rdy    (mem_rdy),
        .state      (state),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int tg, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s tag=%0d got=%0h want=%0h", nm, tg, act, exp);
        end
    endtask

    task automatic check_all(input int tg, input logic [8:0] e_st, input logic [1:0] e_code, input logic [3:0] e_ret);
        cmp("state",      tg, 32'(state),      32'(e_st));
        cmp("busy",       tg, 32'(busy),       32'(|e_st[6:1]));
        cmp("fault",      tg, 32'(fault),      32'(e_st[8]));
        cmp("fault_code", tg, 32'(fault_code), 32'(e_code));
        cmp("retired",    tg, 32'(retired),    32'(e_ret));
    endtask

    // Monitor: compare every queued expectation just after the edge it refers to
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check_all(int'(mon_e.tag), mon_e.st, mon_e.code, mon_e.ret);
        end
    end

    function automatic logic [8:0] xb(input logic [1:0] f);
        logic [8:0] b;
        b = S_E0 << f;
        return b;
    endfunction

    // Drive one cycle of inputs and queue the state expected after the next edge
    task automatic step(input logic i_en, input logic i_res, input logic [1:0] i_fn,
                        input logic i_halt, input logic i_req, input logic i_rdy,
                        input logic [8:0] e_st, input logic [1:0] e_code, input int tg);
        exp_t e;
        @(negedge clk);
        en = i_en; resume = i_res; func = i_fn; halt = i_halt; mem_req = i_req; mem_rdy = i_rdy;
        if (last_st == S_PCI) exp_ret = exp_ret + 4'd1;
        last_st = e_st;
        e.st = e_st; e.code = e_code; e.ret = exp_ret; e.tag = 16'(tg);
        q.push_back(e);
    endtask

    // From FETCH: memory ready, decode fn, single-cycle exec, pc increment
    task automatic instr(input logic [1:0] fn, input logic en_after, input int tg);
        step(1, 0, 2'd0, 0, 0, 1, S_DEC,  2'd0, tg);
        step(1, 0, fn,   0, 0, 0, xb(fn), 2'd0, tg + 1);
        step(1, 0, 2'd0, 0, 0, 0, S_PCI,  2'd0, tg + 2);
        step(en_after, 0, 2'd0, 0, 0, 0, en_after ? S_FETCH : S_IDLE, 2'd0, tg + 3);
    endtask

    // Asynchronous reset pulse placed between clock edges, checked immediately
    task automatic do_reset(input int tg);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all(tg, S_IDLE, 2'd0, 4'd0);
        en = 0; resume = 0; func = 0; halt = 0; mem_req = 0; mem_rdy = 0;
        #1 rst = 1'b1;
        exp_ret = 4'd0;
        last_st = S_IDLE;
    endtask

    initial begin
        rst = 1'b0; en = 0; resume = 0; func = 0; halt = 0; mem_req = 0; mem_rdy = 0;
        repeat (2) @(negedge clk);
        do_reset(1);

        // Basic instruction: mem_rdy on 2nd FETCH cycle, func=1, no mem_req
        step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 100);
        step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 101);
        instr(2'd1, 1'b1, 102);

        // Fetch timeout: 15 FETCH cycles without mem_rdy, resume ignored in FAULT
        for (int i = 0; i < 14; i++) step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 200 + i);
        step(1, 0, 2'd0, 0, 0, 0, S_FLT, 2'd1, 214);
        step(1, 1, 2'd0, 0, 0, 0, S_FLT, 2'd1, 215);
        step(1, 0, 2'd0, 0, 0, 1, S_FLT, 2'd1, 216);
        do_reset(217);

        // mem_rdy in the limit cycle wins over the timeout; en dropped at PC_INC
        step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 300);
        for (int i = 0; i < 14; i++) step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 301 + i);
        instr(2'd2, 1'b0, 315);

        // Illegal func traps with code 3
        step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 400);
        step(1, 0, 2'd0, 0, 0, 1, S_DEC,   2'd0, 401);
        step(1, 0, 2'd3, 0, 0, 0, S_FLT,   2'd3, 402);
        step(0, 1, 2'd0, 0, 0, 0, S_FLT,   2'd3, 403);
        do_reset(404);

        // Halt outranks illegal func; en ignored while halted; resume to IDLE
        step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 500);
        step(1, 0, 2'd0, 0, 0, 1, S_DEC,   2'd0, 501);
        step(1, 0, 2'd3, 1, 0, 0, S_HALT,  2'd0, 502);
        step(1, 0, 2'd0, 0, 0, 0, S_HALT,  2'd0, 503);
        step(0, 1, 2'd0, 0, 0, 0, S_IDLE,  2'd0, 504);
        step(0, 0, 2'd0, 0, 0, 1, S_IDLE,  2'd0, 505);

        // EXEC_0 with mem_req: mem_rdy in 5th cycle, mem_req only sampled first cycle
        step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 600);
        step(1, 0, 2'd0, 0, 0, 1, S_DEC,   2'd0, 601);
        step(1, 0, 2'd0, 0, 0, 0, S_E0,    2'd0, 602);
        step(1, 0, 2'd0, 0, 1, 0, S_E0,    2'd0, 603);
        for (int i = 0; i < 3; i++) step(1, 0, 2'd0, 0, 0, 0, S_E0, 2'd0, 604 + i);
        step(1, 0, 2'd0, 0, 0, 1, S_PCI,   2'd0, 607);
        step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 608);

        // Same without mem_rdy: exec timeout after 15 EXEC cycles, code 2
        step(1, 0, 2'd0, 0, 0, 1, S_DEC,   2'd0, 700);
        step(1, 0, 2'd0, 0, 0, 0, S_E0,    2'd0, 701);
        step(1, 0, 2'd0, 0, 1, 0, S_E0,    2'd0, 702);
        for (int i = 0; i < 13; i++) step(1, 0, 2'd0, 0, 0, 0, S_E0, 2'd0, 703 + i);
        step(1, 0, 2'd0, 0, 0, 0, S_FLT,   2'd2, 716);
        do_reset(717);

        // en dropped during EXEC: instruction completes, returns to IDLE
        step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 800);
        step(1, 0, 2'd0, 0, 0, 1, S_DEC,   2'd0, 801);
        step(1, 0, 2'd1, 0, 0, 0, S_E1,    2'd0, 802);
        step(0, 0, 2'd0, 0, 0, 0, S_PCI,   2'd0, 803);
        step(0, 0, 2'd0, 0, 0, 0, S_IDLE,  2'd0, 804);

        // Async reset mid-FETCH with retired=1
        step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 805);
        step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 806);
        do_reset(807);

        // 16 instructions on a 4-bit counter: retired wraps 15 -> 0
        step(1, 0, 2'd0, 0, 0, 0, S_FETCH, 2'd0, 900);
        for (int i = 0; i < 16; i++) instr(2'(i % 3), 1'b1, 1000 + 4 * i);
        step(0, 0, 2'd0, 0, 0, 1, S_DEC,   2'd0, 1100);
        cmp("wrap_model", 1101, 32'(exp_ret), 32'd0);

        // Drain the scoreboard with a bounded wait
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain tag=0 got=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
